// File: rtl/sw_input_ctrl_pkg.sv
// Shared register map and bus constants for the switch-input block.
// Latency: n/a; backpressure: n/a.
package sw_input_ctrl_pkg;

    localparam int BUS_W = 32;

    // Register select values, taken from addr[3:2]
    localparam logic [1:0] REG_STATE  = 2'd0;
    localparam logic [1:0] REG_EDGE   = 2'd1;
    localparam logic [1:0] REG_FIELD  = 2'd2;
    localparam logic [1:0] REG_IRQ_EN = 2'd3;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, debounce counter, stable level and change pulse.
// Latency: stable moves DB_CYCLES+2 edges after the pin change is sampled; backpressure: none.
module sw_debounce_bit #(
    parameter int DB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic stable,
    output logic chg
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // chg is high on exactly the cycle whose edge moves stable to s2
    assign chg = (s2 != stable) && (cnt == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sw_input_ctrl.sv
// Debounced switch inputs with sticky change flags, maskable irq and a 4-register read/write port.
// Latency: rdata one cycle after rd_en, irq one cycle after flag/enable change; backpressure: none.
module sw_input_ctrl
    import sw_input_ctrl_pkg::*;
#(
    parameter int N_SW      = 16,
    parameter int DB_CYCLES = 20000,
    parameter int FIELD_LO  = 8,
    parameter int FIELD_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  sw,
    input  logic [3:0]       addr,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [BUS_W-1:0] wdata,
    output logic [BUS_W-1:0] rdata,
    output logic             irq
);

    logic [N_SW-1:0]  stable;
    logic [N_SW-1:0]  chg;
    logic [N_SW-1:0]  edge_flags;
    logic [N_SW-1:0]  irq_en;
    logic [1:0]       sel;
    logic             edge_clr;
    logic [BUS_W-1:0] rd_mux;
    logic             unused_bits;

    assign sel         = addr[3:2];
    assign edge_clr    = rd_en && (sel == REG_EDGE);
    assign unused_bits = ^{addr[1:0], wdata};

    for (genvar g = 0; g < N_SW; g++) begin : g_db
        sw_debounce_bit #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .sw     (sw[g]),
            .stable (stable[g]),
            .chg    (chg[g])
        );
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_STATE:  rd_mux = BUS_W'(stable);
            REG_EDGE:   rd_mux = BUS_W'(edge_flags);
            REG_FIELD:  rd_mux = BUS_W'(stable[FIELD_LO +: FIELD_W]);
            REG_IRQ_EN: rd_mux = BUS_W'(irq_en);
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_flags <= '0;
            irq_en     <= '0;
            rdata      <= '0;
            irq        <= 1'b0;
        end else begin
            // A change accepted on the clearing-read edge survives the clear
            edge_flags <= (edge_flags & ~{N_SW{edge_clr}}) | chg;
            if (wr_en && (sel == REG_IRQ_EN)) begin
                irq_en <= wdata[N_SW-1:0];
            end
            if (rd_en) begin
                rdata <= rd_mux;
            end
            irq <= |(edge_flags & irq_en);
        end
    end

endmodule

// File: tb/tb_sw_input_ctrl.sv
// Directed plus random stimulus against a sliding-window reference model of the switch block.
module tb_sw_input_ctrl;

    localparam int N  = 16;
    localparam int DB = 4;
    localparam int FL = 8;
    localparam int FW = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] sw = '0;
    logic [3:0]   addr = '0;
    logic         rd_en = 1'b0;
    logic         wr_en = 1'b0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic         irq;

    sw_input_ctrl #(
        .N_SW      (N),
        .DB_CYCLES (DB),
        .FIELD_LO  (FL),
        .FIELD_W   (FW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .addr  (addr),
        .rd_en (rd_en),
        .wr_en (wr_en),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: a bit is accepted once the pin, seen two edges late,
    // has differed from the accepted level for DB consecutive edges since the last acceptance.
    logic [N-1:0] m_stable, m_edge, m_en;
    logic [31:0]  m_rdata;
    logic         m_irq;
    int           n;
    int           lastf [N];
    logic [N-1:0] swh [0:4095];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {16'b0, m_stable};
            2'd1:    return {16'b0, m_edge};
            2'd2:    return {30'b0, m_stable[FL +: FW]};
            default: return {16'b0, m_en};
        endcase
    endfunction

    task automatic model_reset();
        m_stable = '0;
        m_edge   = '0;
        m_en     = '0;
        m_rdata  = '0;
        m_irq    = 1'b0;
        n        = 0;
        for (int b = 0; b < N; b++) lastf[b] = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] chg_m;
        logic [31:0]  rdv;
        logic         irq_nx;
        logic         ok;
        logic         v;
        int           k;
        n++;
        if (n < 4096) swh[n] = sw;
        chg_m = '0;
        for (int b = 0; b < N; b++) begin
            ok = (n - lastf[b] >= DB);
            for (int j = 0; j < DB; j++) begin
                k = n - 2 - j;
                v = (k >= 1) ? swh[k][b] : 1'b0;
                if (v == m_stable[b]) ok = 1'b0;
            end
            chg_m[b] = ok;
        end
        rdv    = mread(addr);
        irq_nx = |(m_edge & m_en);
        if (rd_en) m_rdata = rdv;
        m_irq    = irq_nx;
        m_stable = m_stable ^ chg_m;
        for (int b = 0; b < N; b++) if (chg_m[b]) lastf[b] = n;
        if (rd_en && addr[3:2] == 2'd1) m_edge = '0;
        m_edge = m_edge | chg_m;
        if (wr_en && addr[3:2] == 2'd3) m_en = wdata[N-1:0];
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        chk("rdata", rdata, m_rdata);
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cycle();
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        addr  = a;
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        d     = rdata;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        cycle();
        wr_en = 1'b0;
    endtask

    logic [31:0] d;

    initial begin
        model_reset();
        #12;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;

        // All registers read zero out of reset
        for (int r = 0; r < 4; r++) begin
            rd(4'(r * 4), d);
            chk("reset_read", d, 32'h0);
        end

        // 0x0300: stable moves on the 6th edge, visible to a read one edge later
        sw = 16'h0300;
        idle(5);
        rd(4'h0, d);
        chk("state_before", d, 32'h0);
        rd(4'h0, d);
        chk("state_0300", d, 32'h300);
        rd(4'h8, d);
        chk("field", d, 32'h3);
        rd(4'h4, d);
        chk("edge_0300", d, 32'h300);
        rd(4'h4, d);
        chk("edge_cleared", d, 32'h0);

        // Glitch shorter than the window is rejected
        sw[0] = 1'b1;
        idle(DB - 1);
        sw[0] = 1'b0;
        idle(10);
        rd(4'h0, d);
        chk("glitch_state", d, 32'h300);
        rd(4'h4, d);
        chk("glitch_edge", d, 32'h0);
        chk("glitch_irq", {31'b0, irq}, 32'h0);

        // Enabled bit raises irq, read clears it; disabled bit stays quiet
        wr(4'hC, 32'h1);
        rd(4'hC, d);
        chk("irq_en_rb", d, 32'h1);
        sw[0] = 1'b1;
        idle(DB + 2);
        chk("irq_low_at_set", {31'b0, irq}, 32'h0);
        idle(1);
        chk("irq_high", {31'b0, irq}, 32'h1);
        rd(4'h4, d);
        chk("edge_bit0", d, 32'h1);
        idle(1);
        chk("irq_fall", {31'b0, irq}, 32'h0);
        sw[1] = 1'b1;
        idle(DB + 6);
        chk("irq_masked", {31'b0, irq}, 32'h0);
        rd(4'h4, d);
        chk("edge_bit1", d, 32'h2);

        // Read on the acceptance edge: excluded now, present next read
        sw[5] = 1'b1;
        idle(DB + 1);
        rd(4'h4, d);
        chk("edge_race_first", d, 32'h0);
        rd(4'h4, d);
        chk("edge_race_second", d, 32'h20);

        // Same-cycle write and read of IRQ_EN returns the old value
        addr  = 4'hC;
        wdata = 32'hFFFF_00F0;
        wr_en = 1'b1;
        rd_en = 1'b1;
        cycle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("rw_same_cycle", rdata, 32'h1);
        rd(4'hC, d);
        chk("irq_en_upper", d, 32'h00F0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) sw[$urandom_range(0, N - 1)] ^= 1'b1;
            addr  = 4'($urandom_range(0, 15));
            rd_en = ($urandom_range(0, 3) == 0);
            wr_en = ($urandom_range(0, 15) == 0);
            wdata = $urandom;
            cycle();
        end
        rd_en = 1'b0;
        wr_en = 1'b0;

        // Reset mid-debounce
        sw = 16'h0000;
        idle(DB + 8);
        rd(4'h4, d);
        sw[3] = 1'b1;
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_reset_rdata", rdata, 32'h0);
        chk("mid_reset_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(DB + 1);
        rd(4'h0, d);
        chk("post_reset_early", d, 32'h0);
        rd(4'h0, d);
        chk("post_reset_state", d, 32'h8);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sw_input_ctrl.md
# sw_input_ctrl

Parametrised switch-input peripheral on the SoC data bus, the successor to the plain combinational switch field. Synchronises and debounces N_SW board switches and latches per-bit change events into sticky flags with a maskable interrupt. Exposes the debounced state, the change flags and one configurable bit-field through a small register-mapped read/write port.

## Interface
- N_SW, 16, number of switch inputs (1..32)
- DB_CYCLES, 20000, stable cycles required before a new level is accepted (≥2)
- FIELD_LO, 8, LSB position of the FIELD register slice
- FIELD_W, 2, width of the FIELD register slice (FIELD_LO+FIELD_W ≤ N_SW)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- sw  in  N_SW  raw asynchronous switch pins
- addr  in  4  byte address within block; bits [3:2] select register
- rd_en  in  1  read strobe, one cycle
- wr_en  in  1  write strobe, one cycle
- wdata  in  32  write data
- rdata  out  32  read data, registered
- irq  out  1  level interrupt, registered

## Operation
- Register map (word-aligned; addr[1:0] ignored):
  - 0x0 STATE (RO): debounced value, zero-extended to 32 bits.
  - 0x4 EDGE (RO, clear-on-read): sticky per-bit change flags, zero-extended.
  - 0x8 FIELD (RO): debounced[FIELD_LO+FIELD_W-1:FIELD_LO], zero-extended.
  - 0xC IRQ_EN (RW): per-bit interrupt enable, low N_SW bits; upper bits read 0.
- Synchroniser: two flops per bit, sw → s1 → s2.
- Debounce, per bit, own counter of width clog2(DB_CYCLES):
  - s2 == stable: counter cleared to 0.
  - s2 != stable: counter increments; when counter == DB_CYCLES-1 on that cycle, stable <= s2, counter <= 0, and edge flag for that bit is set.
  - Any glitch (s2 returns to stable) before terminal count restarts the count from 0.
- EDGE flags: set by any accepted change (rise or fall). Cleared only by a read of 0x4; if a change is accepted on the same cycle as the clearing read, set wins for that bit.
- irq <= |(edge & irq_en), registered each cycle.
- Writes to 0x0/0x4/0x8 ignored. Read and write on the same cycle: both performed; a read of 0xC returns the pre-write value.
- Reset values: s1, s2, stable, counters, edge, irq_en, rdata, irq all 0. A switch held high at reset produces an accepted change (and edge flag) DB_CYCLES+2 cycles after release of reset.

## Timing
- rdata valid the cycle after rd_en; holds its value until the next rd_en.
- Pin to stable latency: 2 sync cycles + DB_CYCLES cycles, i.e. stable updates on the (DB_CYCLES+2)th rising edge after the pin change is first sampled.
- Edge flag updates on the same edge as stable; irq rises one cycle later.
- EDGE clear takes effect on the rd_en edge; irq falls the following cycle.
- IRQ_EN write takes effect on the wr_en edge; irq reflects it one cycle later.
- Reset mid-debounce: all counts and flags lost immediately (asynchronous); no event is generated for the interrupted change until a full DB_CYCLES window elapses after reset release.

## Structure
- Shared SoC package: register offsets (STATE, EDGE, FIELD, IRQ_EN) as localparams and the 32-bit bus width constant.
- One sub-module, sw_debounce_bit: synchroniser + counter + stable flop + change pulse for one bit, parameter DB_CYCLES; instantiated N_SW times via generate. Top level holds edge/irq_en registers, read mux and irq.

## Test plan
- Reset with sw=0: all reads return 0x0000_0000, irq=0.
- DB_CYCLES=4: set sw=16'h0300 → STATE reads 0x300 and FIELD reads 0x3 from cycle 6 after change; EDGE reads 0x300, second EDGE read returns 0.
- Glitch: sw[0] high for DB_CYCLES-1 cycles then low → STATE and EDGE unchanged, irq stays 0.
- Write IRQ_EN=0x1, toggle sw[0] → irq=1 one cycle after edge set; read EDGE → 0x1, irq=0 the next cycle; toggle sw[1] only → irq stays 0.
- Accepted change on the same cycle as EDGE read → returned value excludes it, flag remains set, next read returns it.
- Assert rst_n mid-debounce with sw[3] pending → all outputs 0 at once; after release, STATE bit 3 sets exactly DB_CYCLES+2 cycles later.
